// File: rtl/down_timer_if.sv
// down_timer_if: control/status bundle for the loadable down-counter timer.
//   master : the controlling FSM (drives commands, observes count/status)
//   slave  : the timer itself
// Signals:
//   load, load_val : write the reload register and the counter
//   start, stop    : (re)start from the reload value / abort and hold
//   en             : count enable (0 pauses a running count)
//   periodic       : 1 = auto-reload at expiry, 0 = one-shot
//   q              : current count
//   tc             : one-cycle registered terminal-count pulse
//   busy, expired  : RUN / EXPIRED state flags
interface down_timer_if #(
  parameter int N = 8
);
  logic         load;
  logic [N-1:0] load_val;
  logic         start;
  logic         stop;
  logic         en;
  logic         periodic;
  logic [N-1:0] q;
  logic         tc;
  logic         busy;
  logic         expired;

  modport master (
    output load, load_val, start, stop, en, periodic,
    input  q, tc, busy, expired
  );

  modport slave (
    input  load, load_val, start, stop, en, periodic,
    output q, tc, busy, expired
  );
endinterface

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with a programmable reload register,
// one-shot or periodic auto-reload, and a one-cycle terminal-count pulse.
// Expiry happens rl+1 enabled cycles after start.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   tmr   : down_timer_if.slave control/status bundle
//
// state   | meaning
// --------+-------------------------------------------
// IDLE    | not counting, q holds
// RUN     | counting down while en=1
// EXPIRED | one-shot finished, q=0
module down_timer #(
  parameter int           N            = 8,
  parameter logic [N-1:0] RESET_RELOAD = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  down_timer_if.slave tmr
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_EXPIRED = 2'd2;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] rl_q, rl_d;
  logic         tc_q, tc_d;

  // Command ladder: load > stop > start > count. An asserted stop blocks
  // start even when it has nothing to abort.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rl_d    = rl_q;
    tc_d    = 1'b0;
    if (tmr.load) begin
      rl_d    = tmr.load_val;
      q_d     = tmr.load_val;
      state_d = S_IDLE;
    end else if (tmr.stop) begin
      if (state_q == S_RUN) begin
        state_d = S_IDLE;
      end
    end else if (tmr.start) begin
      // A zero reload would never expire meaningfully, so start is ignored.
      if (rl_q != '0) begin
        q_d     = rl_q;
        state_d = S_RUN;
      end
    end else if (state_q == S_RUN && tmr.en) begin
      if (q_q != '0) begin
        q_d = q_q - ONE;
      end else begin
        tc_d = 1'b1;
        if (tmr.periodic) begin
          q_d = rl_q;
        end else begin
          state_d = S_EXPIRED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      rl_q    <= RESET_RELOAD;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rl_q    <= rl_d;
      tc_q    <= tc_d;
    end
  end

  assign tmr.q       = q_q;
  assign tmr.tc      = tc_q;
  assign tmr.busy    = (state_q == S_RUN);
  assign tmr.expired = (state_q == S_EXPIRED);

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: scoreboard bench for down_timer. Each cycle the expected
// post-edge outputs are queued as the stimulus is driven, then popped and
// compared one time unit after the rising edge.
module tb_down_timer;
  logic clk;
  logic rst_n;

  down_timer_if #(.N(8)) tif ();

  down_timer #(.N(8), .RESET_RELOAD(8'd255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tmr   (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       tc;
    logic       busy;
    logic       expd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tc_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic ld, input logic [7:0] lv, input logic st,
                     input logic sp, input logic e, input logic per);
    tif.load     = ld;
    tif.load_val = lv;
    tif.start    = st;
    tif.stop     = sp;
    tif.en       = e;
    tif.periodic = per;
  endtask

  task automatic chk_now(input string tag, input logic [7:0] eq, input logic etc,
                         input logic eb, input logic ee);
    chk({tag, ".q"},       {24'b0, tif.q},       {24'b0, eq});
    chk({tag, ".tc"},      {31'b0, tif.tc},      {31'b0, etc});
    chk({tag, ".busy"},    {31'b0, tif.busy},    {31'b0, eb});
    chk({tag, ".expired"}, {31'b0, tif.expired}, {31'b0, ee});
  endtask

  task automatic tick(input string tag, input logic [7:0] eq, input logic etc,
                      input logic eb, input logic ee);
    exp_t e;
    exp_t o;
    e.tag = tag; e.q = eq; e.tc = etc; e.busy = eb; e.expd = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (tif.tc === 1'b1) tc_cnt++;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      o = sb.pop_front();
      chk_now(o.tag, o.q, o.tc, o.busy, o.expd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    cmd(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #3;
    chk_now("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: one-shot from 3
    cmd(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("t1_load", 8'd3, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("t1_start", 8'd3, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tc_cnt = 0;
    tick("t1_q2", 8'd2, 1'b0, 1'b1, 1'b0);
    tick("t1_q1", 8'd1, 1'b0, 1'b1, 1'b0);
    tick("t1_q0", 8'd0, 1'b0, 1'b1, 1'b0);
    tick("t1_exp", 8'd0, 1'b1, 1'b0, 1'b1);
    tick("t1_hold1", 8'd0, 1'b0, 1'b0, 1'b1);
    tick("t1_hold2", 8'd0, 1'b0, 1'b0, 1'b1);
    chk("t1_tc_count", tc_cnt, 32'd1);

    // 2: periodic reload of 2, 12 enabled cycles
    cmd(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("t2_load", 8'd2, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("t2_start", 8'd2, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      int p;
      p = (i + 1) % 3;
      tick("t2_run", (p == 0) ? 8'd2 : 8'(2 - p), (p == 0), 1'b1, 1'b0);
    end
    chk("t2_tc_count", tc_cnt, 32'd4);
    cmd(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick("t2_stop", 8'd2, 1'b0, 1'b0, 1'b0);

    // 3: pause with en=0
    cmd(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("t3_load", 8'd5, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("t3_start", 8'd5, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tc_cnt = 0;
    tick("t3_q4", 8'd4, 1'b0, 1'b1, 1'b0);
    tick("t3_q3", 8'd3, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick("t3_pause", 8'd3, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("t3_q2", 8'd2, 1'b0, 1'b1, 1'b0);
    tick("t3_q1", 8'd1, 1'b0, 1'b1, 1'b0);
    tick("t3_q0", 8'd0, 1'b0, 1'b1, 1'b0);
    tick("t3_exp", 8'd0, 1'b1, 1'b0, 1'b1);
    tick("t3_after", 8'd0, 1'b0, 1'b0, 1'b1);
    chk("t3_tc_count", tc_cnt, 32'd1);

    // 4: stop beats start in the same cycle
    cmd(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("t4_load", 8'd6, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("t4_start", 8'd6, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("t4_q5", 8'd5, 1'b0, 1'b1, 1'b0);
    tick("t4_q4", 8'd4, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick("t4_stop_start", 8'd4, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("t4_restart", 8'd6, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("t4_start_in_run", 8'd6, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick("t4_stop", 8'd6, 1'b0, 1'b0, 1'b0);

    // 5: zero reload ignores start, then reload of 1
    cmd(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("t5_load0", 8'd0, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tc_cnt = 0;
    tick("t5_start0", 8'd0, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick("t5_idle0", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("t5_no_tc", tc_cnt, 32'd0);
    cmd(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("t5_load1", 8'd1, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("t5_start1", 8'd1, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("t5_q0", 8'd0, 1'b0, 1'b1, 1'b0);
    tick("t5_exp", 8'd0, 1'b1, 1'b0, 1'b1);

    // 6: async reset while tc is high in a periodic run
    cmd(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("t6_load", 8'd7, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("t6_start", 8'd7, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) tick("t6_run", 8'(i), 1'b0, 1'b1, 1'b0);
    tick("t6_tc", 8'd7, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_now("t6_async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("t6_start255", 8'd255, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("t6_q254", 8'd254, 1'b0, 1'b1, 1'b0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
